// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder:
// FSM state encoding, naturally aligned byte-lane masks and lane helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b1100;
    localparam logic [3:0] MASK_W  = 4'b1111;

    localparam logic [31:0] RSP_ZERO = 32'h0000_0000;

    // The empty mask counts as aligned: it is a legal no-op access.
    function automatic logic mask_is_legal(input logic [3:0] mask);
        return mask inside {4'b0000, MASK_B0, MASK_B1, MASK_B2, MASK_B3,
                            MASK_H0, MASK_H1, MASK_W};
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage with a byte-lane-enabled synchronous write
// port and a synchronous read port.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the storage has no reset on purpose; contents are undefined after
    // power-up, and a reset branch would force it out of RAM macros into flops.
    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en[b]) begin
                mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one masked load/store at a time over
// valid/ready request and response handshakes.
// Define DMEM_ERR_CHECK_EN to flag out-of-range word indices and misaligned
// masks; otherwise indices wrap modulo DEPTH_WORDS and any mask is honoured.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [3:0]  i_req_mask,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        state, state_next;
    logic [2:0]    cnt, cnt_next;
    logic          access;

    logic          cap_write;
    logic          cap_err;
    logic [AW-1:0] cap_idx;
    logic [3:0]    cap_mask;
    logic [31:0]   cap_wdata;

    logic [AW-1:0] req_idx;
    logic          req_err;
    logic          unused_addr;

    logic          acc_write;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic [3:0]    acc_mask;
    logic [31:0]   acc_wdata;

    logic [3:0]    wr_en;
    logic          rd_en;
    logic [31:0]   rd_data;

    assign req_idx = i_req_addr[AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
    assign req_err = (i_req_addr[31:AW+2] != '0) || !mask_is_legal(i_req_mask);
`else
    assign req_err = 1'b0;
`endif

    assign unused_addr = ^{i_req_addr[31:AW+2], i_req_addr[1:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_err   <= 1'b0;
            cap_idx   <= '0;
            cap_mask  <= '0;
            cap_wdata <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && i_req_valid) begin
                cap_write <= i_req_write;
                cap_err   <= req_err;
                cap_idx   <= req_idx;
                cap_mask  <= i_req_mask;
                cap_wdata <= i_req_wdata;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        o_req_ready = 1'b0;
        access      = 1'b0;
        case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    cnt_next = 3'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        access     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                // The final decrement coincides with the access edge.
                cnt_next = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_next = RESP;
                    access     = 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // With LATENCY==1 the access happens on the accept edge, before capture.
    assign acc_write = (state == IDLE) ? i_req_write : cap_write;
    assign acc_err   = (state == IDLE) ? req_err     : cap_err;
    assign acc_idx   = (state == IDLE) ? req_idx     : cap_idx;
    assign acc_mask  = (state == IDLE) ? i_req_mask  : cap_mask;
    assign acc_wdata = (state == IDLE) ? i_req_wdata : cap_wdata;

    assign wr_en = (access && acc_write && !acc_err) ? acc_mask : 4'b0000;
    assign rd_en = access && !acc_write && !acc_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (i_clk),
        .wr_en   (wr_en),
        .wr_addr (acc_idx),
        .wr_data (acc_wdata),
        .rd_en   (rd_en),
        .rd_addr (acc_idx),
        .rd_data (rd_data)
    );

    // Read data is only refreshed on an access, so it stays put throughout RESP.
    assign o_rsp_valid = (state == RESP);
    assign o_rsp_err   = (state == RESP) && cap_err;
    assign o_rsp_rdata = (state == RESP && !cap_write && !cap_err)
                       ? (rd_data & lane_bits(cap_mask))
                       : RSP_ZERO;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized
// traffic against a byte-level memory model kept in the bench.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

`ifdef DMEM_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_write = 1'b0;
    logic [31:0] i_req_addr = '0;
    logic [3:0]  i_req_mask = '0;
    logic [31:0] i_req_wdata = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    int n_checks = 0;
    int n_errors = 0;
    int cycle = 0;
    int last_accept = 0;
    int last_hold = 0;
    bit spacing_ok = 1'b0;

    logic [7:0] mem_b [DEPTH*4];

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_write (i_req_write),
        .i_req_addr  (i_req_addr),
        .i_req_mask  (i_req_mask),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Byte-granular reference: a word is four bytes, a mask picks which ones.
    task automatic model_access(input bit wr, input logic [31:0] addr, input logic [3:0] mask,
                                input logic [31:0] wdata, output logic [31:0] rdata,
                                output logic err);
        int unsigned idx;
        idx   = addr >> 2;
        err   = ERR_EN && ((idx >= DEPTH) ||
                !(mask inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0011, 4'b1100, 4'b1111}));
        rdata = 32'h0;
        idx   = idx % DEPTH;
        if (!err) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) begin
                    if (wr) mem_b[idx*4 + b] = wdata[8*b +: 8];
                    else    rdata[8*b +: 8] = mem_b[idx*4 + b];
                end
            end
        end
    endtask

    task automatic scramble_req();
        i_req_write = 1'($urandom_range(0, 1));
        i_req_addr  = $urandom;
        i_req_mask  = 4'($urandom_range(0, 15));
        i_req_wdata = $urandom;
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        i_rst_n     = 1'b0;
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n    = 1'b1;
        spacing_ok = 1'b0;
    endtask

    // One full transaction: accept, latency, optional backpressure, handshake.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] wdata, input int hold, input string tag,
                          output logic [31:0] got);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          waited;
        model_access(wr, addr, mask, wdata, exp_rdata, exp_err);
        got = 'x;
        @(negedge i_clk);
        check({tag, ".idle_ready"}, 32'(o_req_ready), 32'd1);
        check({tag, ".idle_valid"}, 32'(o_rsp_valid), 32'd0);
        i_req_valid = 1'b1;
        i_req_write = wr;
        i_req_addr  = addr;
        i_req_mask  = mask;
        i_req_wdata = wdata;
        i_rsp_ready = 1'($urandom_range(0, 1));
        @(posedge i_clk);
        #1;
        if (spacing_ok) check({tag, ".spacing"}, 32'(cycle - last_accept), 32'(LAT + 1 + last_hold));
        last_accept = cycle;
        last_hold   = hold;
        spacing_ok  = 1'b1;
        i_req_valid = 1'b0;
        scramble_req();
        waited = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge i_clk);
            if (o_rsp_valid) begin
                waited = k;
                break;
            end
            check({tag, ".busy_ready"}, 32'(o_req_ready), 32'd0);
            i_rsp_ready = 1'($urandom_range(0, 1));
            i_req_valid = 1'($urandom_range(0, 1));
            scramble_req();
        end
        check({tag, ".latency"}, 32'(waited), 32'(LAT));
        if (waited == 0) begin
            apply_reset();
            return;
        end
        got = o_rsp_rdata;
        for (int s = 0; s <= hold; s++) begin
            check({tag, ".valid"}, 32'(o_rsp_valid), 32'd1);
            check({tag, ".rsp_ready_block"}, 32'(o_req_ready), 32'd0);
            check({tag, ".rdata"}, o_rsp_rdata, exp_rdata);
            check({tag, ".err"}, 32'(o_rsp_err), 32'(exp_err));
            if (s == hold) begin
                i_rsp_ready = 1'b1;
                i_req_valid = 1'b0;
            end else begin
                i_rsp_ready = 1'b0;
                i_req_valid = 1'($urandom_range(0, 1));
                scramble_req();
                @(negedge i_clk);
            end
        end
        @(posedge i_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] old;
        logic [31:0] dummy_r;
        logic        dummy_e;
        logic [31:0] addr;
        int unsigned idx;
        int          hold;

        #2;
        i_rst_n = 1'b0;
        #1;
        check("reset.req_ready", 32'(o_req_ready), 32'd1);
        check("reset.rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("reset.rsp_rdata", o_rsp_rdata, 32'd0);
        check("reset.rsp_err",   32'(o_rsp_err),   32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int w = 0; w < 16; w++) begin
            do_req(1'b1, 32'(w * 4), 4'hF, $urandom, 0, "init", got);
        end

        do_req(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 0, "st_full", got);
        do_req(1'b0, 32'h10, 4'b1111, 32'h0, 0, "ld_full", got);
        check("ld_full.const", got, 32'hDEADBEEF);

        do_req(1'b1, 32'h10, 4'b0100, 32'h00AA0000, 0, "st_lane2", got);
        do_req(1'b0, 32'h10, 4'b1111, 32'h0, 0, "ld_merged", got);
        check("ld_merged.const", got, 32'hDEAABEEF);
        do_req(1'b0, 32'h10, 4'b1100, 32'h0, 0, "ld_upper", got);
        check("ld_upper.const", got, 32'hDEAA0000);

        do_req(1'b0, 32'h10, 4'b1111, 32'h0, 5, "backpressure", got);

        do_req(1'b1, 32'h14, 4'b0000, 32'h12345678, 0, "st_nomask", got);
        do_req(1'b0, 32'h14, 4'b0000, 32'h0, 0, "ld_nomask", got);
        do_req(1'b0, 32'h14, 4'b1111, 32'h0, 0, "ld_after_nomask", got);

        do_req(1'b1, 32'h400, 4'b1111, 32'hCAFEF00D, 0, "st_oob", got);
        do_req(1'b0, 32'h0, 4'b1111, 32'h0, 0, "ld_alias0", got);
        do_req(1'b1, 32'h18, 4'b0110, 32'h55667788, 0, "st_mask0110", got);
        do_req(1'b0, 32'h18, 4'b1111, 32'h0, 0, "ld_mask0110", got);

        old = {mem_b[8*4+3], mem_b[8*4+2], mem_b[8*4+1], mem_b[8*4+0]};
        @(negedge i_clk);
        check("rst_mid.pre_ready", 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b1;
        i_req_write = 1'b1;
        i_req_addr  = 32'h20;
        i_req_mask  = 4'hF;
        i_req_wdata = ~old;
        @(posedge i_clk);
        #2;
        i_req_valid = 1'b0;
        i_rst_n     = 1'b0;
        #1;
        check("rst_mid.req_ready", 32'(o_req_ready), 32'd1);
        check("rst_mid.rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_mid.rsp_rdata", o_rsp_rdata, 32'd0);
        check("rst_mid.rsp_err",   32'(o_rsp_err),   32'd0);
        // With single-cycle latency the store has already committed on accept.
        if (LAT == 1) model_access(1'b1, 32'h20, 4'hF, ~old, dummy_r, dummy_e);
        repeat (3) begin
            @(negedge i_clk);
            check("rst_mid.no_rsp", 32'(o_rsp_valid), 32'd0);
        end
        i_rst_n    = 1'b1;
        spacing_ok = 1'b0;
        do_req(1'b0, 32'h20, 4'hF, 32'h0, 0, "rst_mid.reload", got);
        check("rst_mid.prior", got, (LAT == 1) ? ~old : old);

        for (int t = 0; t < 200; t++) begin
            idx = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) idx = idx + DEPTH * $urandom_range(1, 3);
            addr = 32'(idx << 2) | 32'($urandom_range(0, 3));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            do_req(1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)), $urandom,
                   hold, "rand", got);
        end

        @(negedge i_clk);
        check("final.req_ready", 32'(o_req_ready), 32'd1);
        check("final.rsp_valid", 32'(o_rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
